// File: rtl/dlx_pkg.sv
// Shared DLX definitions: NOP word, IF state encoding, IF/ID bundle
// and the default reset PC.
package dlx_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        BUF   = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc_plus4} holding buffer for the fetch stage.
// Ports: clk, rst_n, load/drain/flush controls, load data, held data.
module if_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= '0;
            pc_plus4 <= '0;
        end else if (flush || drain) begin
            instr    <= '0;
            pc_plus4 <= '0;
        end else if (load) begin
            instr    <= load_instr;
            pc_plus4 <= load_pc_plus4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// DLX instruction fetch: PC, imem request/ready port, skid buffer,
// branch redirect and IF/ID register (instr_out, pc_plus4_out,
// valid_out). Inputs: clk, reset (async, active-low), stall,
// branch_taken/branch_target, imem_ready/imem_rdata. Outputs:
// imem_req/imem_addr plus IF/ID. Define IF_STATS_EN to add
// stall_cycles and squash_count saturating counters.
module if_stage
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
`ifdef IF_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] squash_count
`endif
);

    if_state_e   state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pend, pend_next;
    if_id_t      ifid, ifid_next;
    if_id_t      bubble;

    logic        buf_load, buf_drain, buf_flush;
    logic [31:0] buf_instr, buf_pc_plus4;

    logic [31:0] pc_inc;
    logic [31:0] tgt;
    logic        unused_tgt_bits;

    assign pc_inc          = pc + 32'd4;
    assign tgt             = {branch_target[31:2], 2'b00};
    assign unused_tgt_bits = ^branch_target[1:0];
    assign bubble          = '{instr: NOP, pc_plus4: ifid.pc_plus4, valid: 1'b0};

    assign imem_req     = reset && (state != BUF);
    assign imem_addr    = pc;
    assign instr_out    = ifid.instr;
    assign pc_plus4_out = ifid.pc_plus4;
    assign valid_out    = ifid.valid;

    if_skid_buf u_skid (
        .clk          (clk),
        .rst_n        (reset),
        .load         (buf_load),
        .drain        (buf_drain),
        .flush        (buf_flush),
        .load_instr   (imem_rdata),
        .load_pc_plus4(pc_inc),
        .instr        (buf_instr),
        .pc_plus4     (buf_pc_plus4)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc;
        pend_next  = pend;
        ifid_next  = ifid;
        buf_load   = 1'b0;
        buf_drain  = 1'b0;
        buf_flush  = 1'b0;
        unique case (state)
            FETCH: begin
                if (branch_taken) begin
                    ifid_next = bubble;
                    if (imem_ready) begin
                        pc_next = tgt;
                    end else begin
                        // old address stays on the bus until accepted
                        pend_next  = tgt;
                        state_next = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_next = pc_inc;
                    if (stall) begin
                        buf_load   = 1'b1;
                        state_next = BUF;
                    end else begin
                        ifid_next = '{instr: imem_rdata,
                                      pc_plus4: pc_inc,
                                      valid: 1'b1};
                    end
                end else if (!stall) begin
                    ifid_next = bubble;
                end
            end
            BUF: begin
                if (branch_taken) begin
                    buf_flush  = 1'b1;
                    pc_next    = tgt;
                    ifid_next  = bubble;
                    state_next = FETCH;
                end else if (!stall) begin
                    buf_drain  = 1'b1;
                    ifid_next  = '{instr: buf_instr,
                                   pc_plus4: buf_pc_plus4,
                                   valid: 1'b1};
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    pend_next = tgt;
                    ifid_next = bubble;
                end
                // stale word is dropped; newest target wins
                if (imem_ready) begin
                    pc_next    = branch_taken ? tgt : pend;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            pend  <= '0;
            ifid  <= '{instr: NOP, pc_plus4: 32'h0, valid: 1'b0};
        end else begin
            state <= state_next;
            pc    <= pc_next;
            pend  <= pend_next;
            ifid  <= ifid_next;
        end
    end

`ifdef IF_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            squash_count <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && (squash_count != '1)) begin
                squash_count <= squash_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan checks with literal values,
// then randomized traffic against a queue-based fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;

    logic        w_stall = 1'b0;
    logic        w_branch = 1'b0;
    logic [31:0] w_target = 32'h0;
    logic        w_ready = 1'b1;
    logic [31:0] w_rdata;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;

`ifdef IF_STATS_EN
    logic [31:0] stall_cycles, squash_count;
    logic [31:0] w_stall_cycles, w_squash_count;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1;
    endfunction

    assign imem_rdata = imem_ready ? f(imem_addr) : 32'hBAD0_BAD0;
    assign w_rdata    = f(w_addr);

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_plus4_out (pc_plus4_out),
        .valid_out    (valid_out)
`ifdef IF_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .squash_count (squash_count)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk          (clk),
        .reset        (reset),
        .stall        (w_stall),
        .branch_taken (w_branch),
        .branch_target(w_target),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_ready   (w_ready),
        .imem_rdata   (w_rdata),
        .instr_out    (w_instr),
        .pc_plus4_out (w_pc4),
        .valid_out    (w_valid)
`ifdef IF_STATS_EN
        ,
        .stall_cycles (w_stall_cycles),
        .squash_count (w_squash_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the fetch unit viewed as an address stream, a queue of
    // held words, and a "stale request still owed" flag.
    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    ent_t        skid[$];
    ent_t        e;
    logic [31:0] m_pc = 32'h0;
    logic        owed = 1'b0;
    logic [31:0] m_tgt = 32'h0;
    logic [31:0] o_i = 32'h0;
    logic [31:0] o_p = 32'h0;
    logic        o_v = 1'b0;
    logic [31:0] tg;
    logic [31:0] st_c = 32'h0;
    logic [31:0] sq_c = 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 32'h0;
            skid.delete();
            owed = 1'b0;
            m_tgt = 32'h0;
            o_i = 32'h0;
            o_p = 32'h0;
            o_v = 1'b0;
            st_c = 32'h0;
            sq_c = 32'h0;
        end else begin
            tg = branch_target & 32'hFFFF_FFFC;
            if (stall && st_c != 32'hFFFF_FFFF) st_c = st_c + 1;
            if (branch_taken && sq_c != 32'hFFFF_FFFF) sq_c = sq_c + 1;
            if (branch_taken) begin
                o_i = 32'h0;
                o_v = 1'b0;
            end
            if (skid.size() != 0) begin
                if (branch_taken) begin
                    skid.delete();
                    m_pc = tg;
                end else if (!stall) begin
                    e = skid.pop_front();
                    o_i = e.i;
                    o_p = e.p;
                    o_v = 1'b1;
                end
            end else if (owed) begin
                if (branch_taken) m_tgt = tg;
                if (imem_ready) begin
                    m_pc = m_tgt;
                    owed = 1'b0;
                end
            end else if (branch_taken) begin
                if (imem_ready) begin
                    m_pc = tg;
                end else begin
                    owed = 1'b1;
                    m_tgt = tg;
                end
            end else if (imem_ready) begin
                if (stall) begin
                    skid.push_back('{f(m_pc), m_pc + 32'd4});
                end else begin
                    o_i = f(m_pc);
                    o_p = m_pc + 32'd4;
                    o_v = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end else if (!stall) begin
                o_i = 32'h0;
                o_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("req", {31'b0, imem_req}, {31'b0, reset && skid.size() == 0});
        check("addr", imem_addr, m_pc);
        check("instr", instr_out, o_i);
        check("pc4", pc_plus4_out, o_p);
        check("valid", {31'b0, valid_out}, {31'b0, o_v});
`ifdef IF_STATS_EN
        check("stall_cycles", stall_cycles, st_c);
        check("squash_count", squash_count, sq_c);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc4", pc_plus4_out, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("w_rst_addr", w_addr, 32'hFFFF_FFFC);
        #1 reset = 1'b1;
        imem_ready = 1'b1;
        cyc();
        check("seq_addr4", imem_addr, 32'h4);
        check("seq_pc4_4", pc_plus4_out, 32'h4);
        check("seq_instr0", instr_out, f(32'h0));
        check("seq_valid", {31'b0, valid_out}, 32'h1);
        check("w_wrap_addr", w_addr, 32'h0);
        check("w_wrap_pc4", w_pc4, 32'h0);
        cyc();
        check("seq_addr8", imem_addr, 32'h8);
        check("seq_pc4_8", pc_plus4_out, 32'h8);
        #1 imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("wait_addr", imem_addr, 32'h8);
            check("wait_bubble_v", {31'b0, valid_out}, 32'h0);
            check("wait_bubble_i", instr_out, 32'h0);
        end
        #1 imem_ready = 1'b1;
        cyc();
        check("wait_pc4", pc_plus4_out, 32'hC);
        check("wait_instr", instr_out, f(32'h8));
        cyc();
        check("pre_stall_addr", imem_addr, 32'h10);
        #1 stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("stall_req", {31'b0, imem_req}, 32'h0);
            check("stall_pc4", pc_plus4_out, 32'h10);
            check("stall_instr", instr_out, f(32'hC));
        end
        #1 stall = 1'b0;
        cyc();
        check("unstall_instr", instr_out, f(32'h10));
        check("unstall_pc4", pc_plus4_out, 32'h14);
        check("unstall_addr", imem_addr, 32'h14);
        cyc();
        check("next_pc4", pc_plus4_out, 32'h18);
        check("next_instr", instr_out, f(32'h14));
        #1 imem_ready = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0102;
        cyc();
        check("drain_valid", {31'b0, valid_out}, 32'h0);
        check("drain_hold_addr", imem_addr, 32'h18);
        #1 branch_taken = 1'b0;
        cyc();
        check("drain_hold_addr2", imem_addr, 32'h18);
        #1 imem_ready = 1'b1;
        cyc();
        check("redir_addr", imem_addr, 32'h100);
        check("redir_valid", {31'b0, valid_out}, 32'h0);
        cyc();
        check("redir_instr", instr_out, f(32'h100));
        check("redir_pc4", pc_plus4_out, 32'h104);
        #1 stall = 1'b1;
        cyc();
        check("buf_req", {31'b0, imem_req}, 32'h0);
        #1 branch_taken = 1'b1;
        branch_target = 32'h200;
        cyc();
        check("bufbr_valid", {31'b0, valid_out}, 32'h0);
        check("bufbr_instr", instr_out, 32'h0);
        check("bufbr_addr", imem_addr, 32'h200);
        #1 branch_taken = 1'b0;
        stall = 1'b0;
        cyc();
        check("bufbr_next", instr_out, f(32'h200));
        check("bufbr_pc4", pc_plus4_out, 32'h204);

        for (int k = 0; k < 1500; k++) begin
            #1;
            imem_ready = ($urandom_range(3) != 0);
            stall = ($urandom_range(3) == 0);
            branch_taken = ($urandom_range(9) == 0);
            branch_target = $urandom;
            cyc();
        end

        #1 imem_ready = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'h0);
        check("async_instr", instr_out, 32'h0);
        check("async_pc4", pc_plus4_out, 32'h0);
        check("async_valid", {31'b0, valid_out}, 32'h0);
        check("async_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 200; k++) begin
            cyc();
            #1;
            imem_ready = ($urandom_range(2) != 0);
            stall = ($urandom_range(4) == 0);
            branch_taken = ($urandom_range(7) == 0);
            branch_target = $urandom;
        end
        cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined DLX core, directly upstream of instruction decode. It owns the program counter and drives a request/ready instruction-memory port. It tolerates variable memory latency, holds fetched words in a one-entry skid buffer while decode is stalled, and squashes work on a taken-branch redirect. Its registered outputs form the IF/ID pipeline register consumed by decode.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset; word aligned.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- stall  in  1  hazard-unit hold; 1 = IF/ID register must not change.
- branch_taken  in  1  one-cycle redirect pulse from the branch-resolving stage.
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request; address must stay stable until accepted.
- imem_addr  out  32  fetch address (current PC).
- imem_ready  in  1  request accepted; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr_out  out  32  IF/ID instruction; 32'h0 (NOP) when not valid.
- pc_plus4_out  out  32  IF/ID address of the next sequential instruction.
- valid_out  out  1  IF/ID holds a real instruction.

## Operation
- States: FETCH, BUF, DRAIN.
  - imem_req = 1 in FETCH and DRAIN, 0 in BUF, and 0 while reset is asserted.
  - imem_addr = pc.
- FETCH, imem_ready=1, no redirect:
  - pc <= pc+4.
  - stall=0: IF/ID <= {imem_rdata, pc+4, valid=1}.
  - stall=1: skid buffer <= {imem_rdata, pc+4}; state becomes BUF.
- FETCH, imem_ready=0, stall=0: valid_out <= 0 and instr_out <= NOP (bubble).
- FETCH, imem_ready=0, stall=1: IF/ID is held.
- BUF: stall=0 moves the buffer into IF/ID with valid=1, and the state becomes FETCH.
- Redirect (branch_taken=1) has priority over stall. In all cases valid_out <= 0 and instr_out <= NOP.
  - FETCH with imem_ready=1: the returned data is discarded; pc <= target; stay in FETCH.
  - FETCH with imem_ready=0: pending_target <= target; state becomes DRAIN. The outstanding address is held until accepted.
  - DRAIN: pending_target is overwritten by the newest target.
  - BUF: the buffer is dropped; pc <= target; state becomes FETCH.
- DRAIN with imem_ready=1: the data is discarded; pc <= pending_target; state becomes FETCH. IF/ID keeps its bubble.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - pc = RESET_PC; state = FETCH; imem_req = 0.
  - instr_out = 0; pc_plus4_out = 0; valid_out = 0; buffer and pending_target = 0.
- After reset deasserts, imem_req rises in the first cycle.
- Latency: a word accepted at edge N appears on instr_out after edge N (registered, one cycle).
- Zero-wait memory gives one instruction per cycle.
- A buffered word reaches IF/ID at the first edge where stall=0. imem_req resumes the following cycle.
- Redirect costs at least one bubble. In DRAIN it costs the additional memory wait cycles.
- Reset mid-operation clears everything asynchronously. In-flight requests are abandoned and the memory side must tolerate this.

## Configuration
- IF_STATS_EN defined:
  - Adds output ports stall_cycles[31:0] and squash_count[31:0].
  - stall_cycles increments on every cycle with stall=1.
  - squash_count increments on every branch_taken pulse.
  - Both counters saturate at all-ones and reset to 0.
- IF_STATS_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package dlx_pkg holds:
  - the NOP constant 32'h0000_0000;
  - the IF state enumeration (FETCH, BUF, DRAIN);
  - the default RESET_PC.
- Sub-module if_skid_buf: the one-entry {instr, pc_plus4} buffer with load/drain/flush controls.
- The PC, FSM and IF/ID register live in if_stage.

## Test plan
- Reset release, imem_ready tied 1, rdata = addr-derived words:
  - imem_addr goes 0, 4, 8 in consecutive cycles.
  - valid_out=1 from cycle 2, with pc_plus4_out 4, 8, 12.
- imem_ready low for 3 cycles at addr 8:
  - imem_addr held at 8 and 3 bubbles (valid_out=0, instr_out=0).
  - The word then arrives with pc_plus4_out=12.
- stall=1 for 4 cycles while a word at 16 returns:
  - IF/ID is unchanged and imem_req=0 after capture.
  - When stall drops, instr_out = the word from 16 and pc_plus4_out=20, with no duplicate or lost word.
- branch_taken with target 0x100 while a request is outstanding (ready delayed 2 cycles):
  - The stale data is discarded.
  - The next imem_addr is 0x100, and valid_out=0 until the word from 0x100 arrives.
- branch_taken and stall together in BUF: the buffer is dropped, valid_out=0, and fetch resumes at the target.
- RESET_PC=32'hFFFF_FFFC: the second fetch is at address 0. Asserting reset mid-fetch clears all outputs immediately.
